// File: rtl/bin2bcd_pkg.sv
// Shared types, widths and BCD weight constants for the sequential
// binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int BIN_W = 10;
    localparam int BCD_W = 16;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACC  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [3:0] IDX_FIRST = 4'd4;
    localparam logic [3:0] IDX_LAST  = 4'd9;

    localparam logic [11:0] W_B4 = 12'h016;
    localparam logic [11:0] W_B5 = 12'h032;
    localparam logic [11:0] W_B6 = 12'h064;
    localparam logic [11:0] W_B7 = 12'h128;
    localparam logic [11:0] W_B8 = 12'h256;
    localparam logic [11:0] W_B9 = 12'h512;

    function automatic logic [BCD_W-1:0] weight_bcd(input logic [3:0] idx);
        logic [11:0] w;
        case (idx)
            4'd4:    w = W_B4;
            4'd5:    w = W_B5;
            4'd6:    w = W_B6;
            4'd7:    w = W_B7;
            4'd8:    w = W_B8;
            4'd9:    w = W_B9;
            default: w = '0;
        endcase
        return {4'h0, w};
    endfunction

    // Low nibble 0..15 as BCD: 10..15 become 16'h0010..16'h0015.
    function automatic logic [BCD_W-1:0] bcd_low(input logic [3:0] v);
        if (v > 4'd9) return {12'h001, v - 4'd10};
        return {12'h000, v};
    endfunction

endpackage

// File: rtl/bcd_weight_add.sv
// Combinational BCD accumulate: adds the weight of binary bit idx_i to sum_i
// when bit_i is set, using per-digit decimal-adjusted addition.
module bcd_weight_add
    import bin2bcd_pkg::*;
(
    input  logic [3:0]       idx_i,
    input  logic             bit_i,
    input  logic [BCD_W-1:0] sum_i,
    output logic [BCD_W-1:0] sum_o
);

    logic [BCD_W-1:0] w;
    logic [4:0]       digit;
    logic             carry;

    always_comb begin
        w     = bit_i ? weight_bcd(idx_i) : '0;
        carry = 1'b0;
        digit = '0;
        sum_o = '0;
        for (int unsigned d = 0; d < 4; d++) begin
            digit = {1'b0, sum_i[4*d +: 4]} + {1'b0, w[4*d +: 4]} + {4'b0, carry};
            if (digit > 5'd9) begin
                digit = digit + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum_o[4*d +: 4] = digit[3:0];
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle 10-bit binary to 4-digit BCD converter with valid/ready on both
// sides; one shared weight adder is stepped over binary bits 4..9.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned EARLY_DONE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] bin_i,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BCD_W-1:0] bcd_o,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [BIN_W-1:0] opnd_q, opnd_d;
    logic [BCD_W-1:0] sum_q, sum_d;
    logic             out_valid_q, out_valid_d;

    logic [BCD_W-1:0] sum_add;
    logic             upper_zero;
    logic             early;

    assign early      = (EARLY_DONE != 0);
    assign upper_zero = ((opnd_q >> (idx_q + 4'd1)) == '0);

    assign in_ready  = (state_q == ST_IDLE) & ~abort;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign bcd_o     = sum_q;

    bcd_weight_add u_add (
        .idx_i (idx_q),
        .bit_i (opnd_q[idx_q]),
        .sum_i (sum_q),
        .sum_o (sum_add)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        opnd_d      = opnd_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            sum_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        opnd_d = bin_i;
                        sum_d  = bcd_low(bin_i[3:0]);
                        idx_d  = IDX_FIRST;
                        if (early && (bin_i[9:4] == '0)) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    sum_d = sum_add;
                    idx_d = idx_q + 4'd1;
                    if ((idx_q == IDX_LAST) || (early && upper_zero)) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= IDX_FIRST;
            opnd_q      <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            opnd_q      <= opnd_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
